// File: rtl/csa_result_collector.sv
// Frames BATCH carry-select adder results into sum / carry-count / peak with a held output slot.
// Define CSA_COLLECT_SAT_EN for a saturating accumulator and the out_ovf flag.
module csa_result_collector #(
    parameter int unsigned BATCH = 8,
    parameter int unsigned ACC_W = 16,
    localparam int unsigned CNT_W = $clog2(BATCH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [8:0]       sum,
    input  logic             cout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_acc,
    output logic [CNT_W-1:0] out_carries,
    output logic [9:0]       out_max,
    output logic             out_ovf
);

    localparam int unsigned IDX_W = $clog2(BATCH);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(BATCH - 1);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_e;

    slot_e             slot_q, slot_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]  ccnt_q, ccnt_d;
    logic [9:0]        vmax_q, vmax_d;
    logic [ACC_W-1:0]  oacc_q, oacc_d;
    logic [CNT_W-1:0]  ocar_q, ocar_d;
    logic [9:0]        omax_q, omax_d;

    logic [9:0]        v;
    logic              is_last;
    logic              accept;
    logic [ACC_W-1:0]  acc_new;
    logic [CNT_W-1:0]  ccnt_new;
    logic [9:0]        vmax_new;

`ifdef CSA_COLLECT_SAT_EN
    logic              ovf_q, ovf_d;
    logic              oovf_q, oovf_d;
    logic [ACC_W:0]    acc_wide;
    logic              ovf_new;

    // One extra bit catches the carry out of the accumulator for clamping.
    always_comb begin
        acc_wide = (ACC_W + 1)'(acc_q) + (ACC_W + 1)'(v);
        acc_new  = acc_wide[ACC_W] ? '1 : acc_wide[ACC_W-1:0];
        ovf_new  = ovf_q | acc_wide[ACC_W];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q  <= 1'b0;
            oovf_q <= 1'b0;
        end else begin
            ovf_q  <= ovf_d;
            oovf_q <= oovf_d;
        end
    end

    assign out_ovf = oovf_q;
`else
    assign acc_new = acc_q + ACC_W'(v);
    assign out_ovf = 1'b0;
`endif

    assign v         = {cout, sum};
    assign is_last   = (idx_q == LAST);
    assign ccnt_new  = ccnt_q + CNT_W'(cout);
    assign vmax_new  = (v > vmax_q) ? v : vmax_q;
    assign in_ready  = !((slot_q == FULL) && is_last);
    assign accept    = in_valid && in_ready && !flush;
    assign out_valid = (slot_q == FULL);
    assign out_acc     = oacc_q;
    assign out_carries = ocar_q;
    assign out_max     = omax_q;

    always_comb begin
        slot_d = slot_q;
        idx_d  = idx_q;
        acc_d  = acc_q;
        ccnt_d = ccnt_q;
        vmax_d = vmax_q;
        oacc_d = oacc_q;
        ocar_d = ocar_q;
        omax_d = omax_q;
`ifdef CSA_COLLECT_SAT_EN
        ovf_d  = ovf_q;
        oovf_d = oovf_q;
`endif

        if ((slot_q == FULL) && out_ready) begin
            slot_d = EMPTY;
        end

        // Flush drops any same-cycle sample and never touches the held frame.
        if (flush || (accept && is_last)) begin
            idx_d  = '0;
            acc_d  = '0;
            ccnt_d = '0;
            vmax_d = '0;
`ifdef CSA_COLLECT_SAT_EN
            ovf_d  = 1'b0;
`endif
        end

        if (accept) begin
            if (is_last) begin
                slot_d = FULL;
                oacc_d = acc_new;
                ocar_d = ccnt_new;
                omax_d = vmax_new;
`ifdef CSA_COLLECT_SAT_EN
                oovf_d = ovf_new;
`endif
            end else begin
                idx_d  = idx_q + 1'b1;
                acc_d  = acc_new;
                ccnt_d = ccnt_new;
                vmax_d = vmax_new;
`ifdef CSA_COLLECT_SAT_EN
                ovf_d  = ovf_new;
`endif
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_q <= EMPTY;
            idx_q  <= '0;
            acc_q  <= '0;
            ccnt_q <= '0;
            vmax_q <= '0;
            oacc_q <= '0;
            ocar_q <= '0;
            omax_q <= '0;
        end else begin
            slot_q <= slot_d;
            idx_q  <= idx_d;
            acc_q  <= acc_d;
            ccnt_q <= ccnt_d;
            vmax_q <= vmax_d;
            oacc_q <= oacc_d;
            ocar_q <= ocar_d;
            omax_q <= omax_d;
        end
    end

endmodule

// File: tb/tb_csa_result_collector.sv
// Directed bench for csa_result_collector: a BATCH=4/ACC_W=16 instance and a BATCH=8/ACC_W=12 instance.
module tb_csa_result_collector;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Instance A: BATCH=4, ACC_W=16
    logic        a_flush = 0, a_in_valid = 0, a_in_ready, a_cout = 0;
    logic [8:0]  a_sum = '0;
    logic        a_out_valid, a_out_ready = 0, a_out_ovf;
    logic [15:0] a_out_acc;
    logic [2:0]  a_out_carries;
    logic [9:0]  a_out_max;

    // Instance B: BATCH=8, ACC_W=12
    logic        b_flush = 0, b_in_valid = 0, b_in_ready, b_cout = 0;
    logic [8:0]  b_sum = '0;
    logic        b_out_valid, b_out_ready = 0, b_out_ovf;
    logic [11:0] b_out_acc;
    logic [3:0]  b_out_carries;
    logic [9:0]  b_out_max;

    csa_result_collector #(.BATCH(4), .ACC_W(16)) dut_a (
        .clk(clk), .rst(rst), .flush(a_flush),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .sum(a_sum), .cout(a_cout),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_acc(a_out_acc), .out_carries(a_out_carries), .out_max(a_out_max), .out_ovf(a_out_ovf)
    );

    csa_result_collector #(.BATCH(8), .ACC_W(12)) dut_b (
        .clk(clk), .rst(rst), .flush(b_flush),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .sum(b_sum), .cout(b_cout),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_acc(b_out_acc), .out_carries(b_out_carries), .out_max(b_out_max), .out_ovf(b_out_ovf)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drive one cycle on instance A from a negedge, return at the next negedge with inputs idle.
    task automatic sa(input logic vld, input logic [9:0] val, input logic ordy, input logic fl);
        a_in_valid = vld; a_sum = val[8:0]; a_cout = val[9]; a_out_ready = ordy; a_flush = fl;
        @(posedge clk); @(negedge clk);
        a_in_valid = 0; a_out_ready = 0; a_flush = 0;
    endtask

    task automatic sb(input logic vld, input logic [9:0] val, input logic ordy, input logic fl);
        b_in_valid = vld; b_sum = val[8:0]; b_cout = val[9]; b_out_ready = ordy; b_flush = fl;
        @(posedge clk); @(negedge clk);
        b_in_valid = 0; b_out_ready = 0; b_flush = 0;
    endtask

    logic [9:0] mixed [4];

    initial begin
        mixed[0] = 10'h200; mixed[1] = 10'h0FF; mixed[2] = 10'h3FF; mixed[3] = 10'h001;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_valid", a_out_valid, 0);
        chk("rst_ready", a_in_ready, 1);
        chk("rst_acc", a_out_acc, 0);
        chk("rst_carries", a_out_carries, 0);
        chk("rst_max", a_out_max, 0);
        chk("rst_ovf", a_out_ovf, 0);
        chk("rst_b_ready", b_in_ready, 1);
        rst = 0;

        // Reset mid-stream discards the partial frame
        sa(1, 100, 0, 0);
        sa(1, 100, 0, 0);
        rst = 1;
        @(posedge clk); @(negedge clk);
        chk("midrst_valid", a_out_valid, 0);
        chk("midrst_ready", a_in_ready, 1);
        chk("midrst_acc", a_out_acc, 0);
        rst = 0;

        // Full-scale frame
        for (int i = 0; i < 3; i++) sa(1, 10'h3FF, 0, 0);
        chk("fs_not_yet", a_out_valid, 0);
        sa(1, 10'h3FF, 0, 0);
        chk("fs_valid", a_out_valid, 1);
        chk("fs_acc", a_out_acc, 4092);
        chk("fs_carries", a_out_carries, 4);
        chk("fs_max", a_out_max, 1023);
        chk("fs_ovf", a_out_ovf, 0);
        sa(0, 0, 1, 0);
        chk("fs_taken", a_out_valid, 0);
        chk("fs_hold_acc", a_out_acc, 4092);

        // Mixed carries
        for (int i = 0; i < 4; i++) sa(1, mixed[i], 0, 0);
        chk("mix_valid", a_out_valid, 1);
        chk("mix_acc", a_out_acc, 1791);
        chk("mix_carries", a_out_carries, 2);
        chk("mix_max", a_out_max, 1023);
        sa(0, 0, 1, 0);

        // Back-pressure: frame 1..4 held, 5..7 accepted, 8 stalls
        for (int i = 1; i <= 4; i++) sa(1, 10'(i), 0, 0);
        chk("bp_valid1", a_out_valid, 1);
        chk("bp_acc1", a_out_acc, 10);
        for (int i = 5; i <= 7; i++) begin
            chk("bp_ready", a_in_ready, 1);
            sa(1, 10'(i), 0, 0);
        end
        chk("bp_stable_acc", a_out_acc, 10);
        chk("bp_stable_valid", a_out_valid, 1);
        chk("bp_stall", a_in_ready, 0);
        sa(1, 8, 1, 0);
        chk("bp_hs_valid", a_out_valid, 0);
        chk("bp_release", a_in_ready, 1);
        chk("bp_hold_acc", a_out_acc, 10);
        sa(1, 8, 0, 0);
        chk("bp_valid2", a_out_valid, 1);
        chk("bp_acc2", a_out_acc, 26);
        chk("bp_max2", a_out_max, 8);
        chk("bp_carries2", a_out_carries, 0);
        sa(0, 0, 1, 0);

        // Flush drops the same-cycle sample and restarts the frame
        sa(1, 100, 0, 0);
        sa(1, 200, 0, 0);
        chk("fl_ready", a_in_ready, 1);
        sa(1, 5, 0, 1);
        for (int i = 1; i <= 3; i++) sa(1, 10'(i), 0, 0);
        chk("fl_not_yet", a_out_valid, 0);
        sa(1, 4, 0, 0);
        chk("fl_valid", a_out_valid, 1);
        chk("fl_acc", a_out_acc, 10);
        chk("fl_max", a_out_max, 4);
        // Flush leaves a held frame alone
        sa(1, 7, 0, 1);
        chk("fl_held_valid", a_out_valid, 1);
        chk("fl_held_acc", a_out_acc, 10);
        sa(0, 0, 1, 0);
        chk("fl_taken", a_out_valid, 0);

        // Throughput with out_ready held high
        for (int i = 1; i <= 8; i++) begin
            chk("tp_ready", a_in_ready, 1);
            sa(1, 10'(i), 1, 0);
            if (i == 4) chk("tp_acc1", a_out_acc, 10);
        end
        chk("tp_valid2", a_out_valid, 1);
        chk("tp_acc2", a_out_acc, 26);

        // Overflow on the narrow accumulator
        for (int i = 0; i < 8; i++) sb(1, 10'h3FF, 0, 0);
        chk("ov_valid", b_out_valid, 1);
        chk("ov_carries", b_out_carries, 8);
        chk("ov_max", b_out_max, 1023);
`ifdef CSA_COLLECT_SAT_EN
        chk("ov_acc", b_out_acc, 4095);
        chk("ov_flag", b_out_ovf, 1);
`else
        chk("ov_acc", b_out_acc, 4088);
        chk("ov_flag", b_out_ovf, 0);
`endif
        chk("ov_ready", b_in_ready, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
